// File: rtl/tl_buffered_coupler.sv
`default_nettype none

// ============================================================================
// Module      : tl_coupler_fifo
// Description : Small valid/ready FIFO for one TileLink channel. Ready is
//               derived from the stored count only, so the pop side never
//               reaches the push side combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_coupler_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push_valid,
    output logic             o_push_ready,
    input  logic [WIDTH-1:0] i_push_bits,
    output logic             o_pop_valid,
    input  logic             i_pop_ready,
    output logic [WIDTH-1:0] o_pop_bits,
    output logic             o_empty
);

    localparam int                 c_ptr_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 c_cnt_w    = $clog2(DEPTH + 1);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_full     = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    // When full the slot is not advertised, even if a pop happens this cycle.
    assign o_push_ready = (r_count != c_full);
    assign o_pop_valid  = (r_count != '0);
    assign o_pop_bits   = r_mem[r_rd_ptr];
    assign o_empty      = (r_count == '0);
    assign w_push       = i_push_valid && o_push_ready;
    assign w_pop        = o_pop_valid && i_pop_ready;

    // Payload storage; contents are meaningless while the count says empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_bits;
        end
    end

    // Pointers wrap modulo DEPTH; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// ============================================================================
// Module      : tl_buffered_coupler
// Description : TileLink A/D coupler with optional channel FIFOs, an
//               in-flight request limiter and a quiesce/idle drain handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_buffered_coupler #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 64,
    parameter int SRC_W        = 4,
    parameter int SINK_W       = 3,
    parameter int A_DEPTH      = 2,
    parameter int D_DEPTH      = 2,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic in_a_valid,
    output logic in_a_ready,
    input  logic [3+3+4+SRC_W+ADDR_W+DATA_W/8+DATA_W+1-1:0] in_a_bits,
    output logic out_a_valid,
    input  logic out_a_ready,
    output logic [3+3+4+SRC_W+ADDR_W+DATA_W/8+DATA_W+1-1:0] out_a_bits,
    input  logic out_d_valid,
    output logic out_d_ready,
    input  logic [3+2+4+SRC_W+SINK_W+1+DATA_W+1-1:0] out_d_bits,
    output logic in_d_valid,
    input  logic in_d_ready,
    output logic [3+2+4+SRC_W+SINK_W+1+DATA_W+1-1:0] in_d_bits,
    input  logic quiesce,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
    output logic idle
);

    localparam int              c_aw       = 3 + 3 + 4 + SRC_W + ADDR_W + DATA_W/8 + DATA_W + 1;
    localparam int              c_dw       = 3 + 2 + 4 + SRC_W + SINK_W + 1 + DATA_W + 1;
    localparam int              c_cw       = $clog2(MAX_INFLIGHT + 1);
    localparam int              c_lg_bytes = $clog2(DATA_W / 8);
    localparam logic [c_cw-1:0] c_max      = c_cw'(MAX_INFLIGHT);

    // Index of the last beat of a message (beats - 1).
    function automatic logic [15:0] f_last_idx(input logic has_data, input logic [3:0] size);
        logic [15:0] v;
        v = '0;
        if (has_data && (int'(size) > c_lg_bytes)) begin
            v = 16'((32'd1 << (int'(size) - c_lg_bytes)) - 32'd1);
        end
        return v;
    endfunction

    logic            w_run;
    logic            w_rst;
    // A channel, master side
    logic [2:0]      w_ain_op;
    logic [3:0]      w_ain_size;
    logic [15:0]     w_ain_last_idx;
    logic            w_ain_first;
    logic            w_ain_fire;
    logic            w_q_block;
    logic            w_a_push_valid;
    logic            w_a_push_ready;
    logic [15:0]     r_ain_cnt;
    // A channel, fabric side
    logic            w_af_valid;
    logic [c_aw-1:0] w_af_bits;
    logic            w_a_pop_ready;
    logic            w_a_empty;
    logic [2:0]      w_aout_op;
    logic [3:0]      w_aout_size;
    logic [15:0]     w_aout_last_idx;
    logic            w_aout_first;
    logic            w_aout_fire;
    logic            w_lim_block;
    logic [15:0]     r_aout_cnt;
    // D channel
    logic            w_d_push_valid;
    logic            w_d_push_ready;
    logic            w_df_valid;
    logic [c_dw-1:0] w_df_bits;
    logic            w_d_pop_ready;
    logic            w_d_empty;
    logic [2:0]      w_dout_op;
    logic [3:0]      w_dout_size;
    logic [15:0]     w_dout_last_idx;
    logic            w_dout_fire;
    logic            w_dout_last;
    logic [15:0]     r_d_cnt;
    // Limiter
    logic            w_a_inc;
    logic            w_d_dec;
    logic [c_cw-1:0] r_inflight;

    assign w_run = reset;
    assign w_rst = !reset;

    // ---------------- A channel, master side (quiesce gate) ----------------
    assign w_ain_op       = in_a_bits[c_aw-1 -: 3];
    assign w_ain_size     = in_a_bits[c_aw-7 -: 4];
    assign w_ain_last_idx = f_last_idx(!w_ain_op[2], w_ain_size);
    assign w_ain_first    = (r_ain_cnt == '0);
    assign w_q_block      = quiesce && in_a_valid && w_ain_first;
    assign w_a_push_valid = in_a_valid && !w_q_block && w_run;
    assign in_a_ready     = w_a_push_ready && !w_q_block && w_run;
    assign w_ain_fire     = in_a_valid && in_a_ready;

    // ---------------- A channel, fabric side (request limiter) -------------
    assign w_aout_op       = w_af_bits[c_aw-1 -: 3];
    assign w_aout_size     = w_af_bits[c_aw-7 -: 4];
    assign w_aout_last_idx = f_last_idx(!w_aout_op[2], w_aout_size);
    assign w_aout_first    = (r_aout_cnt == '0);
    assign w_lim_block     = w_aout_first && (r_inflight == c_max);
    assign out_a_valid     = w_af_valid && !w_lim_block && w_run;
    assign w_a_pop_ready   = out_a_ready && !w_lim_block && w_run;
    assign out_a_bits      = w_af_bits;
    assign w_aout_fire     = out_a_valid && out_a_ready;

    generate
        if (A_DEPTH > 0) begin : g_a_fifo
            tl_coupler_fifo #(.WIDTH(c_aw), .DEPTH(A_DEPTH)) u_a_fifo (
                .clk          (clock),
                .rst          (w_rst),
                .i_push_valid (w_a_push_valid),
                .o_push_ready (w_a_push_ready),
                .i_push_bits  (in_a_bits),
                .o_pop_valid  (w_af_valid),
                .i_pop_ready  (w_a_pop_ready),
                .o_pop_bits   (w_af_bits),
                .o_empty      (w_a_empty)
            );
        end else begin : g_a_wire
            assign w_af_valid     = w_a_push_valid;
            assign w_af_bits      = in_a_bits;
            assign w_a_push_ready = w_a_pop_ready;
            assign w_a_empty      = 1'b1;
        end
    endgenerate

    // ---------------- D channel ----------------
    assign w_d_push_valid  = out_d_valid && w_run;
    assign out_d_ready     = w_d_push_ready && w_run;
    assign w_dout_fire     = out_d_valid && out_d_ready;
    assign w_dout_op       = out_d_bits[c_dw-1 -: 3];
    assign w_dout_size     = out_d_bits[c_dw-6 -: 4];
    assign w_dout_last_idx = f_last_idx((w_dout_op == 3'd1) || (w_dout_op == 3'd5), w_dout_size);
    assign w_dout_last     = (r_d_cnt == w_dout_last_idx);
    assign in_d_valid      = w_df_valid && w_run;
    assign w_d_pop_ready   = in_d_ready && w_run;
    assign in_d_bits       = w_df_bits;

    generate
        if (D_DEPTH > 0) begin : g_d_fifo
            tl_coupler_fifo #(.WIDTH(c_dw), .DEPTH(D_DEPTH)) u_d_fifo (
                .clk          (clock),
                .rst          (w_rst),
                .i_push_valid (w_d_push_valid),
                .o_push_ready (w_d_push_ready),
                .i_push_bits  (out_d_bits),
                .o_pop_valid  (w_df_valid),
                .i_pop_ready  (w_d_pop_ready),
                .o_pop_bits   (w_df_bits),
                .o_empty      (w_d_empty)
            );
        end else begin : g_d_wire
            assign w_df_valid     = w_d_push_valid;
            assign w_df_bits      = out_d_bits;
            assign w_d_push_ready = w_d_pop_ready;
            assign w_d_empty      = 1'b1;
        end
    endgenerate

    // Master-side A beat counter: tells quiesce which beats start a message.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_ain_cnt <= '0;
        end else if (w_ain_fire) begin
            r_ain_cnt <= (r_ain_cnt == w_ain_last_idx) ? '0 : r_ain_cnt + 1'b1;
        end
    end

    // Fabric-side A beat counter: only first beats are subject to the limiter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_aout_cnt <= '0;
        end else if (w_aout_fire) begin
            r_aout_cnt <= (r_aout_cnt == w_aout_last_idx) ? '0 : r_aout_cnt + 1'b1;
        end
    end

    // Fabric-side D beat counter: the last beat of a response retires a request.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_d_cnt <= '0;
        end else if (w_dout_fire) begin
            r_d_cnt <= w_dout_last ? '0 : r_d_cnt + 1'b1;
        end
    end

    assign w_a_inc = w_aout_fire && w_aout_first;
    assign w_d_dec = w_dout_fire && w_dout_last;

    // Outstanding-request counter; saturates at both ends instead of wrapping.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_inflight <= '0;
        end else begin
            case ({w_a_inc, w_d_dec})
                2'b10:   r_inflight <= (r_inflight != c_max) ? r_inflight + 1'b1 : r_inflight;
                2'b01:   r_inflight <= (r_inflight != '0) ? r_inflight - 1'b1 : r_inflight;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign inflight = r_inflight;
    assign idle     = (r_inflight == '0) && w_a_empty && w_d_empty &&
                      (r_ain_cnt == '0) && (r_aout_cnt == '0) && (r_d_cnt == '0);

    // A response that retires a request nobody issued is a protocol error.
    a_no_underflow: assert property (@(posedge clock) disable iff (!reset)
        !(w_d_dec && !w_a_inc && (r_inflight == '0)));

endmodule

`default_nettype wire

// File: tb/tb_tl_buffered_coupler.sv
`default_nettype none

// ============================================================================
// Module      : tb_tl_buffered_coupler
// Description : Directed scoreboard bench for tl_buffered_coupler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tl_buffered_coupler;

    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 64;
    localparam int SRC_W        = 4;
    localparam int SINK_W       = 3;
    localparam int A_DEPTH      = 2;
    localparam int D_DEPTH      = 2;
    localparam int MAX_INFLIGHT = 4;
    localparam int AW           = 119;
    localparam int DW           = 82;
    localparam int CW           = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_a_valid;
    logic          in_a_ready;
    logic [AW-1:0] in_a_bits;
    logic          out_a_valid;
    logic          out_a_ready;
    logic [AW-1:0] out_a_bits;
    logic          out_d_valid;
    logic          out_d_ready;
    logic [DW-1:0] out_d_bits;
    logic          in_d_valid;
    logic          in_d_ready;
    logic [DW-1:0] in_d_bits;
    logic          quiesce;
    logic [CW-1:0] inflight;
    logic          idle;

    tl_buffered_coupler #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W), .SINK_W(SINK_W),
        .A_DEPTH(A_DEPTH), .D_DEPTH(D_DEPTH), .MAX_INFLIGHT(MAX_INFLIGHT)
    ) dut (
        .clock(clock), .reset(reset),
        .in_a_valid(in_a_valid), .in_a_ready(in_a_ready), .in_a_bits(in_a_bits),
        .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_bits(out_a_bits),
        .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_bits(out_d_bits),
        .in_d_valid(in_d_valid), .in_d_ready(in_d_ready), .in_d_bits(in_d_bits),
        .quiesce(quiesce), .inflight(inflight), .idle(idle)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [AW-1:0] bits;
        bit            first;
    } a_exp_t;

    a_exp_t        exp_a[$];
    logic [DW-1:0] exp_d[$];
    a_exp_t        mon_a;
    logic [DW-1:0] mon_d;
    int            n_checks   = 0;
    int            n_errors   = 0;
    int            m_inflight = 0;
    bit            d_cur_last = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] a_pkt(input logic [2:0] op, input logic [3:0] size,
                                            input logic [3:0] src, input logic [63:0] data);
        return {op, 3'd0, size, src, 32'h1000_0000 + {24'd0, src, 4'd0}, 8'hFF, data, 1'b0};
    endfunction

    function automatic logic [DW-1:0] d_pkt(input logic [2:0] op, input logic [3:0] size,
                                            input logic [3:0] src, input logic [63:0] data);
        return {op, 2'd0, size, src, 3'd5, 1'b0, data, 1'b0};
    endfunction

    // Scoreboard: fabric A against pushed requests, master D against pushed
    // responses, and a reference in-flight count built from message boundaries.
    always @(negedge clock) begin
        if (!reset) begin
            m_inflight = 0;
        end else begin
            chk("inflight", 128'(inflight), 128'(m_inflight));
            if (out_a_valid && out_a_ready) begin
                if (exp_a.size() == 0) begin
                    chk("a_unexpected", 128'(out_a_valid), 128'(0));
                end else begin
                    mon_a = exp_a.pop_front();
                    chk("out_a_bits", 128'(out_a_bits), 128'(mon_a.bits));
                    if (mon_a.first) m_inflight++;
                end
            end
            if (out_d_valid && out_d_ready && d_cur_last) m_inflight--;
            if (in_d_valid && in_d_ready) begin
                if (exp_d.size() == 0) begin
                    chk("d_unexpected", 128'(in_d_valid), 128'(0));
                end else begin
                    mon_d = exp_d.pop_front();
                    chk("in_d_bits", 128'(in_d_bits), 128'(mon_d));
                end
            end
        end
    end

    task automatic settle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic a_beat(input logic [AW-1:0] b, input bit first);
        a_exp_t e;
        int     n;
        e.bits  = b;
        e.first = first;
        exp_a.push_back(e);
        in_a_valid = 1'b1;
        in_a_bits  = b;
        n = 0;
        @(negedge clock);
        while (!in_a_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("a_accept", 128'(in_a_ready), 128'(1));
        @(posedge clock);
        #1;
        in_a_valid = 1'b0;
    endtask

    task automatic d_beat(input logic [DW-1:0] b, input bit last);
        int n;
        exp_d.push_back(b);
        d_cur_last  = last;
        out_d_valid = 1'b1;
        out_d_bits  = b;
        n = 0;
        @(negedge clock);
        while (!out_d_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("d_accept", 128'(out_d_ready), 128'(1));
        @(posedge clock);
        #1;
        out_d_valid = 1'b0;
    endtask

    task automatic get(input logic [3:0] src, input logic [3:0] size);
        a_beat(a_pkt(3'd4, size, src, 64'd0), 1'b1);
    endtask

    task automatic ack1(input logic [3:0] src);
        d_beat(d_pkt(3'd1, 4'd3, src, {$urandom, $urandom}), 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clock);
        while (!idle && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk(tag, 128'(idle), 128'(1));
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        quiesce     = 1'b0;
        in_a_valid  = 1'b1;
        in_a_bits   = '0;
        out_a_ready = 1'b1;
        out_d_valid = 1'b1;
        out_d_bits  = '0;
        in_d_ready  = 1'b1;

        // Reset: handshake outputs held low even with traffic offered
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        chk("rst_in_a_ready", 128'(in_a_ready), 128'(0));
        chk("rst_out_a_valid", 128'(out_a_valid), 128'(0));
        chk("rst_out_d_ready", 128'(out_d_ready), 128'(0));
        chk("rst_in_d_valid", 128'(in_d_valid), 128'(0));
        chk("rst_inflight", 128'(inflight), 128'(0));
        chk("rst_idle", 128'(idle), 128'(1));
        @(posedge clock);
        #1;
        in_a_valid  = 1'b0;
        out_d_valid = 1'b0;
        reset       = 1'b1;
        @(negedge clock);
        chk("post_rst_idle", 128'(idle), 128'(1));
        @(posedge clock);
        #1;

        // T1: four back-to-back Gets fill up to the limit
        for (int i = 0; i < 4; i++) get(4'(i), 4'd3);
        settle(2);
        chk("t1_inflight", 128'(inflight), 128'(4));
        chk("t1_a_drained", 128'(exp_a.size()), 128'(0));

        // T2: fifth Get stalls at the limiter until a response retires one
        get(4'd4, 4'd3);
        settle(3);
        @(negedge clock);
        chk("t2_stall_valid", 128'(out_a_valid), 128'(0));
        chk("t2_stall_inflight", 128'(inflight), 128'(4));
        @(posedge clock);
        #1;
        ack1(4'd0);
        settle(3);
        chk("t2_released", 128'(exp_a.size()), 128'(0));
        chk("t2_inflight", 128'(inflight), 128'(4));
        for (int i = 1; i < 5; i++) ack1(4'(i));
        wait_idle("t2_idle");
        chk("t2_d_drained", 128'(exp_d.size()), 128'(0));

        // T3: 4-beat PutFull starting at MAX-1 counts once
        get(4'd0, 4'd5);
        get(4'd1, 4'd3);
        get(4'd2, 4'd3);
        settle(2);
        chk("t3_pre_inflight", 128'(inflight), 128'(3));
        for (int i = 0; i < 4; i++) a_beat(a_pkt(3'd0, 4'd5, 4'd3, {$urandom, $urandom}), i == 0);
        settle(2);
        chk("t3_put_inflight", 128'(inflight), 128'(4));
        chk("t3_put_drained", 128'(exp_a.size()), 128'(0));
        d_beat(d_pkt(3'd0, 4'd5, 4'd3, 64'd0), 1'b1);
        settle(2);
        chk("t3_ack_inflight", 128'(inflight), 128'(3));

        // T4: 4-beat AccessAckData with master D ready toggling
        fork
            begin
                for (int i = 0; i < 3; i++) d_beat(d_pkt(3'd1, 4'd5, 4'd0, {$urandom, $urandom}), 1'b0);
                chk("t4_mid_inflight", 128'(inflight), 128'(3));
                d_beat(d_pkt(3'd1, 4'd5, 4'd0, {$urandom, $urandom}), 1'b1);
            end
            begin
                repeat (12) begin
                    @(posedge clock);
                    #1;
                    in_d_ready = !in_d_ready;
                end
            end
        join
        in_d_ready = 1'b1;
        settle(3);
        chk("t4_inflight", 128'(inflight), 128'(2));
        ack1(4'd1);
        ack1(4'd2);
        wait_idle("t4_idle");
        chk("t4_d_drained", 128'(exp_d.size()), 128'(0));

        // T5: quiesce mid-burst lets the Put finish and holds the next Get
        a_beat(a_pkt(3'd0, 4'd5, 4'd5, {$urandom, $urandom}), 1'b1);
        a_beat(a_pkt(3'd0, 4'd5, 4'd5, {$urandom, $urandom}), 1'b0);
        quiesce = 1'b1;
        a_beat(a_pkt(3'd0, 4'd5, 4'd5, {$urandom, $urandom}), 1'b0);
        a_beat(a_pkt(3'd0, 4'd5, 4'd5, {$urandom, $urandom}), 1'b0);
        in_a_valid = 1'b1;
        in_a_bits  = a_pkt(3'd4, 4'd3, 4'd6, 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("t5_q_block", 128'(in_a_ready), 128'(0));
        end
        @(posedge clock);
        #1;
        d_beat(d_pkt(3'd0, 4'd5, 4'd5, 64'd0), 1'b1);
        wait_idle("t5_idle");
        @(negedge clock);
        chk("t5_still_blocked", 128'(in_a_ready), 128'(0));
        @(posedge clock);
        #1;
        quiesce = 1'b0;
        get(4'd6, 4'd3);
        ack1(4'd6);
        wait_idle("t5_final_idle");

        // T6: reset with requests in flight and both FIFOs occupied
        for (int i = 0; i < 4; i++) get(4'(i), 4'd3);
        settle(2);
        out_a_ready = 1'b0;
        get(4'd4, 4'd3);
        in_d_ready = 1'b0;
        ack1(4'd0);
        settle(1);
        chk("t6_pre_inflight", 128'(inflight), 128'(3));
        reset = 1'b0;
        exp_a.delete();
        exp_d.delete();
        @(posedge clock);
        #1;
        chk("t6_out_a_valid", 128'(out_a_valid), 128'(0));
        chk("t6_in_d_valid", 128'(in_d_valid), 128'(0));
        chk("t6_inflight", 128'(inflight), 128'(0));
        chk("t6_idle", 128'(idle), 128'(1));
        reset       = 1'b1;
        out_a_ready = 1'b1;
        in_d_ready  = 1'b1;
        @(negedge clock);
        chk("t6_post_idle", 128'(idle), 128'(1));
        chk("t6_post_out_a_valid", 128'(out_a_valid), 128'(0));
        @(posedge clock);
        #1;
        get(4'd7, 4'd3);
        ack1(4'd7);
        wait_idle("t6_final_idle");
        chk("t6_a_drained", 128'(exp_a.size()), 128'(0));
        chk("t6_d_drained", 128'(exp_d.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
